// File: rtl/param_updown_step_counter.sv
// Parametrised up/down step counter with all/even/odd/hold modes,
// parallel load, wrap or saturate limits and a registered tc pulse.
// Optional Gray-coded output: define PARAM_UPDOWN_GRAY_OUT_EN.
module param_updown_step_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             y,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef PARAM_UPDOWN_GRAY_OUT_EN
  output logic [WIDTH-1:0] count_gray,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [1:0] M_ALL  = 2'b00;
  localparam logic [1:0] M_EVEN = 2'b01;
  localparam logic [1:0] M_ODD  = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic             w_par_mode;
  logic             w_p;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_min;
  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_tc;

  // Mode-dependent parity, step size and limits
  always_comb begin
    w_par_mode = (mode == M_EVEN) || (mode == M_ODD);
    w_p        = (mode == M_ODD);
    w_step     = (mode == M_ALL) ? WIDTH'(1) : WIDTH'(2);
    w_max      = '1;
    if (mode == M_EVEN) w_max[0] = 1'b0;
    w_min      = '0;
    if (mode == M_ODD) w_min[0] = 1'b1;
    w_at_max   = (r_count == w_max);
    w_at_min   = (r_count == w_min);
    w_load     = load_value;
    if (w_par_mode) w_load[0] = w_p;
  end

  // Next count/tc: hold mode > load > align > step
  always_comb begin
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    if (mode == M_HOLD) begin
      w_next_count = r_count;
    end else if (load) begin
      w_next_count = w_load;
    end else if (enable) begin
      if (w_par_mode && (r_count[0] != w_p)) begin
        w_next_count = {r_count[WIDTH-1:1], w_p};
      end else if (y) begin
        if (w_at_max) begin
          w_next_tc    = 1'b1;
          w_next_count = SATURATE ? r_count : w_min;
        end else begin
          w_next_count = r_count + w_step;
        end
      end else begin
        if (w_at_min) begin
          w_next_tc    = 1'b1;
          w_next_count = SATURATE ? r_count : w_max;
        end else begin
          w_next_count = r_count - w_step;
        end
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_next_tc;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

`ifdef PARAM_UPDOWN_GRAY_OUT_EN
  assign count_gray = r_count ^ (r_count >> 1);
`endif

endmodule
